inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  branch/jump redirect; discards all queued entries.
REQ-005 SHALL have port in_vld  input  1  fetch stage presents a valid instruction.
REQ-006 SHALL have port in_pc  input  32  PC of the presented instruction.
REQ-007 SHALL have port in_inst  input  32  instruction word at in_pc.
REQ-008 SHALL have port hold  output  1  back-pressure to fetch; high = push not accepted this cycle.
REQ-009 SHALL have port out_vld  output  1  decode-side instruction valid.
REQ-010 SHALL have port out_pc  output  32  PC of the head entry.
REQ-011 SHALL have port out_inst  output  32  instruction of the head entry.
REQ-012 SHALL have port out_rdy  input  1  decode stage consumes the head this cycle when out_vld is high.
REQ-013 SHALL have port count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-014 SHALL be a circular FIFO: write pointer, read pointer (clog2(DEPTH) bits, wrapping DEPTH-1 -> 0), occupancy counter.
REQ-015 SHALL define push = in_vld & ~hold & ~flush; pop = out_vld & out_rdy & ~flush.
REQ-016 SHALL drive hold combinationally = (count == DEPTH); hold independent of out_rdy (no same-cycle pass-through when full).
REQ-017 SHALL drive out_vld = (count != 0) (subject to REQ-026), out_pc/out_inst combinationally from the head entry.
REQ-018 SHALL drive out_inst = 32'h0000_0013 (NOP) and out_pc = 0 whenever out_vld is low.
REQ-019 SHALL on push write {in_pc,in_inst} at write pointer and advance it; on pop advance read pointer.
REQ-020 SHALL update count: push only +1, pop only -1, push and pop together unchanged (legal when 1 <= count <= DEPTH-1).
REQ-021 SHALL, with count 0, present a pushed entry at outputs on the following cycle (latency 1 cycle, macro undefined).
REQ-022 SHALL on flush set both pointers and count to 0 at the next edge; in_vld in the flush cycle is discarded, out_vld low from the next cycle.
REQ-023 SHALL give flush priority over push and pop in the same cycle.
REQ-024 SHALL never overflow or underflow: push impossible when full, pop impossible when empty.

Reset
REQ-025 SHALL on rst low immediately clear pointers and count to 0; outputs: hold 0, out_vld 0, out_pc 0, out_inst 32'h0000_0013, count 0; storage contents need not be cleared; reset mid-operation discards all entries.

Configuration
REQ-026 SHALL support macro INST_QUEUE_BYPASS_EN: when defined and count == 0 and in_vld and ~flush, outputs show in_pc/in_inst with out_vld high in the same cycle; if out_rdy also high, the entry is consumed and not written (count stays 0); if out_rdy low, it is written normally.
REQ-027 SHALL, without INST_QUEUE_BYPASS_EN, have no combinational path from in_* to out_*; minimum latency 1 cycle.
REQ-028 SHALL keep hold, flush and reset behaviour identical in both configurations.

Verification
REQ-029 SHALL cover: reset released, in_vld=1 pc=0x0,0x4,0x8 with out_rdy=1 -> out_pc 0x0,0x4,0x8 one cycle after each push (macro off), same cycle (macro on).
REQ-030 SHALL cover: DEPTH=4, out_rdy=0, push pc 0x0..0xC -> count 4, hold=1; push 0x10 held; out_rdy=1 one cycle -> out_pc 0x0 popped, hold drops, count 3.
REQ-031 SHALL cover: count 2, flush=1 with in_vld=1 pc 0x40 -> next cycle count 0, out_vld 0, out_inst 0x00000013; 0x40 not queued.
REQ-032 SHALL cover: count 2, simultaneous push and pop for 6 cycles with wrap -> count stays 2, output order equals input order.
REQ-033 SHALL cover: count 3, rst driven low between edges -> count 0, out_vld 0 immediately, before the next clk edge.
REQ-034 SHALL cover: empty, in_vld=1 pc 0x100, out_rdy=0 (macro on) -> out_vld 1 same cycle, count 1 next cycle, out_pc still 0x100.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular FIFO of {pc, inst} pairs.
// Optional same-cycle fetch-to-decode bypass when empty: define INST_QUEUE_BYPASS_EN.
module inst_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_vld,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_inst,
  output logic                       hold,
  output logic                       out_vld,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;

  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic               bypass_act;
  logic               bypass_take;
  logic               wr_en;
  logic               rd_en;
  entry_t             head;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass_act = empty & in_vld & ~flush;
`else
  assign bypass_act = 1'b0;
`endif

  // A bypassed entry consumed by decode in the same cycle never touches storage.
  assign bypass_take = bypass_act & out_rdy;

  assign hold    = full;
  assign out_vld = ~empty | bypass_act;
  assign push    = in_vld & ~hold & ~flush;
  assign pop     = out_vld & out_rdy & ~flush;
  assign wr_en   = push & ~bypass_take;
  assign rd_en   = pop  & ~bypass_take;
  assign count   = count_q;

  // Output mux: bypass source, queue head, or NOP when nothing is valid.
  always_comb begin
    out_pc   = 32'h0;
    out_inst = NOP;
    if (bypass_act) begin
      out_pc   = in_pc;
      out_inst = in_inst;
    end else if (!empty) begin
      out_pc   = head.pc;
      out_inst = head.inst;
    end
  end

  // Next-state for pointers and occupancy; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= '{pc: in_pc, inst: in_inst};
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=4); bypass-specific expectations follow INST_QUEUE_BYPASS_EN.
module tb_inst_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_vld;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        hold;
  logic        out_vld;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_rdy;
  logic [2:0]  count;

  int tests_run = 0;
  int tests_failed = 0;

  inst_queue #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_vld   (in_vld),
    .in_pc    (in_pc),
    .in_inst  (in_inst),
    .hold     (hold),
    .out_vld  (out_vld),
    .out_pc   (out_pc),
    .out_inst (out_inst),
    .out_rdy  (out_rdy),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
    in_vld  = v;
    in_pc   = pc;
    in_inst = 32'hA000_0000 | pc;
    out_rdy = rdy;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #3;
    chk("rst_count",    32'(count),   32'd0);
    chk("rst_out_vld",  32'(out_vld), 32'd0);
    chk("rst_out_pc",   out_pc,       32'h0);
    chk("rst_out_inst", out_inst,     32'h13);
    chk("rst_hold",     32'(hold),    32'd0);
    #9 rst = 1'b1;
    tick();

    // Streaming with decode always ready
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(4 * i), 1'b1);
      #1;
`ifdef INST_QUEUE_BYPASS_EN
      chk("stream_same_cycle_pc", out_pc, 32'(4 * i));
      chk("stream_same_cycle_vld", 32'(out_vld), 32'd1);
      tick();
      chk("stream_bypass_count", 32'(count), 32'd0);
`else
      if (i == 0) chk("stream_no_passthru", 32'(out_vld), 32'd0);
      tick();
      chk("stream_pc", out_pc, 32'(4 * i));
      chk("stream_inst", out_inst, 32'hA000_0000 | 32'(4 * i));
      chk("stream_count", 32'(count), 32'd1);
`endif
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_out_vld", 32'(out_vld), 32'd0);
    chk("drain_out_inst", out_inst, 32'h13);

    // Fill to full with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0);
      tick();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_hold", 32'(hold), 32'd1);
    drive(1'b1, 32'h10, 1'b0);
    tick();
    chk("held_push_count", 32'(count), 32'd4);
    chk("held_push_head", out_pc, 32'h0);
    drive(1'b1, 32'h10, 1'b1);
    #1;
    chk("full_pop_hold_still", 32'(hold), 32'd1);
    chk("full_pop_head", out_pc, 32'h0);
    tick();
    drive(1'b0, 32'h10, 1'b0);
    chk("after_pop_count", 32'(count), 32'd3);
    chk("after_pop_hold", 32'(hold), 32'd0);
    chk("after_pop_head", out_pc, 32'h4);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("pre_flush_count", 32'(count), 32'd2);
    chk("pre_flush_head", out_pc, 32'h8);

    // Flush beats a concurrent push
    flush = 1'b1;
    drive(1'b1, 32'h40, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_vld", 32'(out_vld), 32'd0);
    chk("flush_out_inst", out_inst, 32'h13);
    chk("flush_out_pc", out_pc, 32'h0);
    tick();
    chk("flush_discard_count", 32'(count), 32'd0);

    // Simultaneous push/pop across pointer wrap
    drive(1'b1, 32'h200, 1'b0); tick();
    drive(1'b1, 32'h204, 1'b0); tick();
    chk("pp_start_count", 32'(count), 32'd2);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h208 + 32'(4 * k), 1'b1);
      #1;
      chk("pp_order", out_pc, 32'h200 + 32'(4 * k));
      tick();
      chk("pp_count", 32'(count), 32'd2);
    end
    drive(1'b0, 32'h0, 1'b0);
    chk("pp_final_head", out_pc, 32'h218);

    // Asynchronous reset between edges
    drive(1'b1, 32'h300, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_out_vld", 32'(out_vld), 32'd0);
    chk("async_rst_out_inst", out_inst, 32'h13);
    #2 rst = 1'b1;
    tick();
    chk("post_rst_count", 32'(count), 32'd0);

    // Push into empty queue with decode stalled
    drive(1'b1, 32'h100, 1'b0);
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    chk("empty_push_vld", 32'(out_vld), 32'd1);
    chk("empty_push_pc", out_pc, 32'h100);
`else
    chk("empty_push_vld", 32'(out_vld), 32'd0);
`endif
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("empty_push_count", 32'(count), 32'd1);
    chk("empty_push_head", out_pc, 32'h100);
    chk("empty_push_out_vld", 32'(out_vld), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
